// File: rtl/ct_ifu_btb_upd_sched.sv
// BTB write-port scheduler: merges IB-stage mispredict updates (1-entry, newest wins),
// backend updates (small FIFO) and the CP0 full-array invalidate onto one write port.
module ct_ifu_btb_upd_sched #(
  parameter int IDX_W      = 10,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst_b,
  input  logic             addrgen_upd_vld,
  input  logic [IDX_W-1:0] addrgen_upd_index,
  input  logic [9:0]       addrgen_upd_tag,
  input  logic [19:0]      addrgen_upd_target,
  input  logic             bju_upd_vld,
  output logic             bju_upd_rdy,
  input  logic [IDX_W-1:0] bju_upd_index,
  input  logic [9:0]       bju_upd_tag,
  input  logic [19:0]      bju_upd_target,
  input  logic             btb_rd_busy,
  input  logic             cp0_btb_inv,
  output logic             sched_btb_wen,
  output logic             sched_btb_vld_bit,
  output logic [IDX_W-1:0] sched_btb_index,
  output logic [9:0]       sched_btb_tag,
  output logic [19:0]      sched_btb_target,
  output logic             sched_cp0_inv_busy,
  output logic             sched_cp0_inv_done,
  output logic             sched_hpcp_upd_drop
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [9:0]       tag;
    logic [19:0]      target;
  } upd_t;

  typedef enum logic [1:0] {S_IDLE, S_INV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] inv_cnt_q, inv_cnt_d;
  logic             hold_vld_q, hold_vld_d;
  upd_t             hold_q, hold_d;
  upd_t             fifo_mem_q [FIFO_DEPTH];
  upd_t             fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy_q, rdy_d;
  logic             drop_q, drop_d;

  logic idle, flush, inv_last;
  logic hold_cap, hold_pop, fifo_push, fifo_pop;
  upd_t ag_pl, bju_pl, fifo_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ag_pl     = '{index: addrgen_upd_index, tag: addrgen_upd_tag, target: addrgen_upd_target};
  assign bju_pl    = '{index: bju_upd_index, tag: bju_upd_tag, target: bju_upd_target};
  assign fifo_head = fifo_mem_q[rd_ptr_q];

  // FSM state register
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  assign inv_last = &inv_cnt_q;

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cp0_btb_inv) state_d = S_INV;
      S_INV:   if (!btb_rd_busy && inv_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: payload is zeroed whenever no write issues
  always_comb begin
    sched_btb_wen      = 1'b0;
    sched_btb_vld_bit  = 1'b0;
    sched_btb_index    = '0;
    sched_btb_tag      = '0;
    sched_btb_target   = '0;
    sched_cp0_inv_busy = 1'b0;
    sched_cp0_inv_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!btb_rd_busy && (hold_vld_q || (cnt_q != '0))) begin
          sched_btb_wen     = 1'b1;
          sched_btb_vld_bit = 1'b1;
          sched_btb_index   = hold_vld_q ? hold_q.index  : fifo_head.index;
          sched_btb_tag     = hold_vld_q ? hold_q.tag    : fifo_head.tag;
          sched_btb_target  = hold_vld_q ? hold_q.target : fifo_head.target;
        end
      end
      S_INV: begin
        sched_cp0_inv_busy = 1'b1;
        if (!btb_rd_busy) begin
          sched_btb_wen   = 1'b1;
          sched_btb_index = inv_cnt_q;
        end
      end
      S_DONE: begin
        sched_cp0_inv_busy = 1'b1;
        sched_cp0_inv_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bju_upd_rdy         = rdy_q;
  assign sched_hpcp_upd_drop = drop_q;

  // Queue control: holding register always beats the FIFO head
  always_comb begin
    idle      = (state_q == S_IDLE);
    flush     = idle && cp0_btb_inv;
    hold_pop  = idle && !btb_rd_busy && hold_vld_q;
    fifo_pop  = idle && !btb_rd_busy && !hold_vld_q && (cnt_q != '0);
    hold_cap  = idle && addrgen_upd_vld && !cp0_btb_inv;
    fifo_push = bju_upd_vld && rdy_q && !cp0_btb_inv;
    drop_d    = hold_cap && hold_vld_q && !hold_pop;

    hold_d     = hold_cap ? ag_pl : hold_q;
    hold_vld_d = hold_vld_q;
    if (flush)         hold_vld_d = 1'b0;
    else if (hold_cap) hold_vld_d = 1'b1;
    else if (hold_pop) hold_vld_d = 1'b0;

    fifo_mem_d = fifo_mem_q;
    if (fifo_push) fifo_mem_d[wr_ptr_q] = bju_pl;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (fifo_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (fifo_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({fifo_push, fifo_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end

    // Counter parks at the last index so it never wraps inside INV
    inv_cnt_d = inv_cnt_q;
    if (flush) inv_cnt_d = '0;
    else if ((state_q == S_INV) && !btb_rd_busy && !inv_last) inv_cnt_d = inv_cnt_q + 1'b1;

    rdy_d = (state_d == S_IDLE) && (cnt_d != CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      hold_vld_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      inv_cnt_q  <= '0;
      rdy_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      hold_vld_q <= hold_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      inv_cnt_q  <= inv_cnt_d;
      rdy_q      <= rdy_d;
      drop_q     <= drop_d;
    end
  end

  // Payload storage carries no reset; validity lives in the control flops
  always_ff @(posedge forever_cpuclk) begin
    hold_q     <= hold_d;
    fifo_mem_q <= fifo_mem_d;
  end

endmodule

// File: tb/tb_ct_ifu_btb_upd_sched.sv
// Directed bench for ct_ifu_btb_upd_sched: inputs change 1ns after the rising edge,
// outputs are compared 2ns after it.
module tb_ct_ifu_btb_upd_sched;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        ag_vld, bju_vld, bju_rdy, busy, inv;
  logic [9:0]  ag_idx, ag_tag, bju_idx, bju_tag;
  logic [19:0] ag_tgt, bju_tgt;
  logic        wen, vbit, ibusy, idone, drop;
  logic [9:0]  widx, wtag;
  logic [19:0] wtgt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ct_ifu_btb_upd_sched #(.IDX_W(10), .FIFO_DEPTH(2)) dut (
    .forever_cpuclk      (clk),
    .cpurst_b            (rst_b),
    .addrgen_upd_vld     (ag_vld),
    .addrgen_upd_index   (ag_idx),
    .addrgen_upd_tag     (ag_tag),
    .addrgen_upd_target  (ag_tgt),
    .bju_upd_vld         (bju_vld),
    .bju_upd_rdy         (bju_rdy),
    .bju_upd_index       (bju_idx),
    .bju_upd_tag         (bju_tag),
    .bju_upd_target      (bju_tgt),
    .btb_rd_busy         (busy),
    .cp0_btb_inv         (inv),
    .sched_btb_wen       (wen),
    .sched_btb_vld_bit   (vbit),
    .sched_btb_index     (widx),
    .sched_btb_tag       (wtag),
    .sched_btb_target    (wtgt),
    .sched_cp0_inv_busy  (ibusy),
    .sched_cp0_inv_done  (idone),
    .sched_hpcp_upd_drop (drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [9:0] idx, input logic [9:0] tg,
                        input logic [19:0] tgt);
    chk({tag, "_wen"}, 32'(wen), 32'd1);
    chk({tag, "_vbit"}, 32'(vbit), 32'd1);
    chk({tag, "_idx"}, 32'(widx), 32'(idx));
    chk({tag, "_tag"}, 32'(wtag), 32'(tg));
    chk({tag, "_tgt"}, 32'(wtgt), 32'(tgt));
  endtask

  task automatic chk_nowr(input string tag);
    chk({tag, "_wen"}, 32'(wen), 32'd0);
    chk({tag, "_idx"}, 32'(widx), 32'd0);
    chk({tag, "_tag"}, 32'(wtag), 32'd0);
    chk({tag, "_tgt"}, 32'(wtgt), 32'd0);
  endtask

  initial begin
    rst_b = 1'b0; ag_vld = 1'b0; bju_vld = 1'b0; busy = 1'b0; inv = 1'b0;
    ag_idx = '0; ag_tag = '0; ag_tgt = '0; bju_idx = '0; bju_tag = '0; bju_tgt = '0;

    // reset state
    tick(); tick(); settle();
    chk_nowr("rst");
    chk("rst_rdy", 32'(bju_rdy), 32'd0);
    chk("rst_ibusy", 32'(ibusy), 32'd0);
    chk("rst_idone", 32'(idone), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    chk("rst_vbit", 32'(vbit), 32'd0);
    rst_b = 1'b1;
    tick(); settle();
    chk("rel_rdy", 32'(bju_rdy), 32'd1);

    // single addrgen update, written the next cycle
    ag_vld = 1'b1; ag_idx = 10'h155; ag_tag = 10'h02A; ag_tgt = 20'h12345;
    settle();
    chk_nowr("ag_lat");
    tick(); ag_vld = 1'b0; settle();
    chk_wr("ag_wr", 10'h155, 10'h02A, 20'h12345);
    chk("ag_drop", 32'(drop), 32'd0);
    tick(); settle();
    chk_nowr("ag_after");

    // two backend updates while the array is busy fill the FIFO
    busy = 1'b1; bju_vld = 1'b1; bju_idx = 10'h011; bju_tag = 10'h001; bju_tgt = 20'hAAAAA;
    settle();
    chk("bjuA_rdy", 32'(bju_rdy), 32'd1);
    chk("bjuA_wen", 32'(wen), 32'd0);
    tick(); bju_idx = 10'h022; bju_tag = 10'h002; bju_tgt = 20'hBBBBB; settle();
    chk("bjuB_rdy", 32'(bju_rdy), 32'd1);
    tick(); bju_vld = 1'b0; busy = 1'b0; settle();
    chk("full_rdy", 32'(bju_rdy), 32'd0);
    chk_wr("bjuA_wr", 10'h011, 10'h001, 20'hAAAAA);
    tick(); settle();
    chk("bjuB_rdy_back", 32'(bju_rdy), 32'd1);
    chk_wr("bjuB_wr", 10'h022, 10'h002, 20'hBBBBB);
    tick(); settle();
    chk_nowr("bju_drained");
    chk("bju_rdy_end", 32'(bju_rdy), 32'd1);

    // push and pop in the same cycle keeps the FIFO moving
    bju_vld = 1'b1; bju_idx = 10'h033; bju_tag = 10'h003; bju_tgt = 20'hCCCCC; settle();
    chk_nowr("pp_first");
    tick(); bju_idx = 10'h044; bju_tag = 10'h004; bju_tgt = 20'hDDDDD; settle();
    chk_wr("pp_C", 10'h033, 10'h003, 20'hCCCCC);
    chk("pp_rdyC", 32'(bju_rdy), 32'd1);
    tick(); bju_vld = 1'b0; settle();
    chk_wr("pp_D", 10'h044, 10'h004, 20'hDDDDD);
    chk("pp_rdyD", 32'(bju_rdy), 32'd1);
    tick(); settle();
    chk_nowr("pp_end");

    // holding register survives a 5-cycle read-busy window
    busy = 1'b1; ag_vld = 1'b1; ag_idx = 10'h0F0; ag_tag = 10'h03C; ag_tgt = 20'h0ABCD; settle();
    chk_nowr("hb_cap");
    tick(); ag_vld = 1'b0;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("hb_wen", 32'(wen), 32'd0);
      chk("hb_drop", 32'(drop), 32'd0);
      tick();
    end
    busy = 1'b0; settle();
    chk_wr("hb_wr", 10'h0F0, 10'h03C, 20'h0ABCD);
    chk("hb_drop_rel", 32'(drop), 32'd0);
    tick(); settle();
    chk_nowr("hb_end");
    chk("hb_drop_end", 32'(drop), 32'd0);

    // overwrite while busy: one drop pulse, newest payload wins
    busy = 1'b1; ag_vld = 1'b1; ag_idx = 10'h101; ag_tag = 10'h011; ag_tgt = 20'h11111; settle();
    tick(); ag_idx = 10'h202; ag_tag = 10'h022; ag_tgt = 20'h22222; settle();
    chk("ow_drop0", 32'(drop), 32'd0);
    tick(); ag_vld = 1'b0; settle();
    chk("ow_drop1", 32'(drop), 32'd1);
    chk("ow_wen_busy", 32'(wen), 32'd0);
    tick(); busy = 1'b0; settle();
    chk("ow_drop_off", 32'(drop), 32'd0);
    chk_wr("ow_wr", 10'h202, 10'h022, 20'h22222);
    tick(); settle();
    chk_nowr("ow_end");

    // capture while draining (no drop) and holding register ahead of FIFO
    ag_vld = 1'b1; ag_idx = 10'h111; ag_tag = 10'h005; ag_tgt = 20'h55555; settle();
    chk_nowr("cd_first");
    tick(); ag_idx = 10'h222; ag_tag = 10'h006; ag_tgt = 20'h66666;
    bju_vld = 1'b1; bju_idx = 10'h0E0; bju_tag = 10'h00E; bju_tgt = 20'hEEEEE; settle();
    chk_wr("cd_X", 10'h111, 10'h005, 20'h55555);
    tick(); ag_vld = 1'b0; bju_vld = 1'b0; settle();
    chk("cd_drop", 32'(drop), 32'd0);
    chk_wr("cd_Y", 10'h222, 10'h006, 20'h66666);
    tick(); settle();
    chk_wr("cd_E", 10'h0E0, 10'h00E, 20'hEEEEE);
    tick(); settle();
    chk_nowr("cd_end");
    chk("cd_drop_end", 32'(drop), 32'd0);

    // full invalidate: 1024 writes, then one done cycle
    inv = 1'b1; ag_idx = 10'h3FF; ag_tag = 10'h3FF; ag_tgt = 20'hFFFFF; settle();
    chk("inv_ibusy0", 32'(ibusy), 32'd0);
    chk("inv_rdy0", 32'(bju_rdy), 32'd1);
    tick();
    for (int i = 0; i < 1024; i++) begin
      ag_vld = (i == 10);
      inv = (i == 500);
      settle();
      chk("inv_wen", 32'(wen), 32'd1);
      chk("inv_vbit", 32'(vbit), 32'd0);
      chk("inv_idx", 32'(widx), 32'(i));
      chk("inv_tag", 32'(wtag), 32'd0);
      chk("inv_ibusy", 32'(ibusy), 32'd1);
      chk("inv_idone", 32'(idone), 32'd0);
      chk("inv_rdy", 32'(bju_rdy), 32'd0);
      chk("inv_drop", 32'(drop), 32'd0);
      tick();
    end
    ag_vld = 1'b0; inv = 1'b0; settle();
    chk("done_idone", 32'(idone), 32'd1);
    chk("done_ibusy", 32'(ibusy), 32'd1);
    chk("done_wen", 32'(wen), 32'd0);
    chk("done_rdy", 32'(bju_rdy), 32'd0);
    tick(); settle();
    chk("post_idone", 32'(idone), 32'd0);
    chk("post_ibusy", 32'(ibusy), 32'd0);
    chk("post_rdy", 32'(bju_rdy), 32'd1);
    chk_nowr("post_inv");
    chk("post_drop", 32'(drop), 32'd0);

    // invalidate with a read stall, aborted by reset at inv_cnt=300
    inv = 1'b1; settle();
    tick(); inv = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i == 5) begin
        busy = 1'b1; settle();
        chk("abt_stall_wen", 32'(wen), 32'd0);
        tick(); busy = 1'b0;
      end
      settle();
      chk("abt_idx", 32'(widx), 32'(i));
      chk("abt_wen", 32'(wen), 32'd1);
      tick();
    end
    settle();
    chk("abt_idx300", 32'(widx), 32'd300);
    rst_b = 1'b0;
    tick(); settle();
    chk("abt_ibusy", 32'(ibusy), 32'd0);
    chk("abt_idone", 32'(idone), 32'd0);
    chk("abt_wen_rst", 32'(wen), 32'd0);
    chk("abt_rdy_rst", 32'(bju_rdy), 32'd0);
    chk("abt_drop", 32'(drop), 32'd0);
    tick(); rst_b = 1'b1; settle();
    chk("abt_idone_rel", 32'(idone), 32'd0);
    tick(); settle();
    chk("abt_rdy_rel", 32'(bju_rdy), 32'd1);
    chk("abt_ibusy_rel", 32'(ibusy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("abt_no_done", 32'(idone), 32'd0);
      chk("abt_no_wen", 32'(wen), 32'd0);
      tick(); settle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
